// File: rtl/noc_xbar_pkg.sv
// noc_xbar_pkg: shared constants, port naming and helpers
// for the switch-traversal crossbar.
package noc_xbar_pkg;

   localparam int XBAR_N     = 5;
   localparam int XBAR_DW    = 32;
   localparam int XBAR_MAX_N = 32;

   typedef enum logic [2:0] {
      P_LOCAL = 3'd0,
      P_NORTH = 3'd1,
      P_EAST  = 3'd2,
      P_SOUTH = 3'd3,
      P_WEST  = 3'd4
   } port_e;

   function automatic logic is_onehot(
      input logic [XBAR_MAX_N-1:0] sel
   );
      return $countones(sel) == 1;
   endfunction

endpackage

// File: rtl/crossbar_out_slice.sv
// crossbar_out_slice: one output of the crossbar -- input mux,
// output register, sticky select error, optional XBAR_PERF_CNT_EN counter.
module crossbar_out_slice
   import noc_xbar_pkg::*;
#(
   parameter int N     = XBAR_N,
   parameter int DW    = XBAR_DW,
   parameter int CNT_W = 16
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic [N-1:0]      sel,
   input  logic [N*DW-1:0]   data_i,
   input  logic [N-1:0]      valid_i,
   input  logic              err_clr_i,
   input  logic              cnt_clr_i,
   output logic [DW-1:0]     data_o,
   output logic              valid_o,
   output logic              sel_err_o,
   output logic [CNT_W-1:0]  flit_cnt_o
);

   logic [XBAR_MAX_N-1:0] sel_ext;
   logic [DW-1:0]         mux_data;
   logic                  onehot;
   logic                  multi;
   logic                  fire;

   // Zero-extend the select so the shared helper can test it.
   always_comb begin
      sel_ext        = '0;
      sel_ext[N-1:0] = sel;
   end

   // AND-OR mux; only one term is live when a flit is forwarded.
   always_comb begin
      mux_data = '0;
      for (int p = 0; p < N; p++) begin
         mux_data = mux_data
                  | (data_i[p*DW +: DW] & {DW{sel[p]}});
      end
   end

   assign onehot = is_onehot(sel_ext);
   assign multi  = (sel != '0) && !onehot;
   assign fire   = onehot && ((sel & valid_i) != '0);

   // Output register; data only loads on a forwarded flit.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         valid_o <= 1'b0;
         data_o  <= '0;
      end else begin
         valid_o <= fire;
         if (fire) begin
            data_o <= mux_data;
         end
      end
   end

   // Sticky multi-hot flag; a new error beats a clear.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         sel_err_o <= 1'b0;
      end else if (multi) begin
         sel_err_o <= 1'b1;
      end else if (err_clr_i) begin
         sel_err_o <= 1'b0;
      end
   end

`ifdef XBAR_PERF_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   // Saturating delivered-flit counter; clear beats increment.
   always_ff @(posedge clk) begin
      if (!rstn || cnt_clr_i) begin
         cnt_q <= '0;
      end else if (fire && (cnt_q != {CNT_W{1'b1}})) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign flit_cnt_o = cnt_q;
`else
   logic unused_cnt_clr;

   assign unused_cnt_clr = cnt_clr_i;
   assign flit_cnt_o     = '0;
`endif

endmodule

// File: rtl/crossbar_pipe.sv
// crossbar_pipe: N-port switch-traversal crossbar, 1-cycle latency.
// Optional per-output flit counters with XBAR_PERF_CNT_EN.
module crossbar_pipe
   import noc_xbar_pkg::*;
#(
   parameter int N     = XBAR_N,
   parameter int DW    = XBAR_DW,
   parameter int CNT_W = 16
) (
   input  logic                clk,
   input  logic                rstn,
   input  logic [N*N-1:0]      sel_i,
   input  logic [N*DW-1:0]     data_i,
   input  logic [N-1:0]        valid_i,
   output logic [N*DW-1:0]     data_o,
   output logic [N-1:0]        valid_o,
   output logic [N-1:0]        sel_err_o,
   input  logic                err_clr_i,
   input  logic                cnt_clr_i,
   output logic [N*CNT_W-1:0]  flit_cnt_o
);

   for (genvar o = 0; o < N; o++) begin : g_out
      crossbar_out_slice #(
         .N     (N),
         .DW    (DW),
         .CNT_W (CNT_W)
      ) u_slice (
         .clk        (clk),
         .rstn       (rstn),
         .sel        (sel_i[o*N +: N]),
         .data_i     (data_i),
         .valid_i    (valid_i),
         .err_clr_i  (err_clr_i),
         .cnt_clr_i  (cnt_clr_i),
         .data_o     (data_o[o*DW +: DW]),
         .valid_o    (valid_o[o]),
         .sel_err_o  (sel_err_o[o]),
         .flit_cnt_o (flit_cnt_o[o*CNT_W +: CNT_W])
      );
   end

endmodule
